// File: rtl/bus_pkg.sv
// Shared definitions for the 32-bit CPU bus and its memory responder.
package bus_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    localparam logic BUS_WRITE = 1'b1;
    localparam logic BUS_READ  = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // True when any address bit above the RAM index field is set.
    function automatic logic out_of_range(input logic [DATA_W-1:0] addr, input int addr_w);
        return (addr >> addr_w) != '0;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM; a read during a write returns the old word.
module mem_array
    import bus_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] index,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Write the addressed word when enabled and register the addressed word every cycle.
    // NOTE: the array has no reset; clearing it would force flops instead of RAM macros,
    // and every sequential assignment is non-blocking so the old word is read on a write.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[index] <= wdata;
        end
        rdata <= mem[index];
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: captures a CPU request, waits a fixed number of cycles,
// then commits the write or presents the read word with a one-cycle ready pulse.
module mem_responder
    import bus_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              rw,
    input  logic [DATA_W-1:0] address,
    input  logic [DATA_W-1:0] datai,
    output logic [DATA_W-1:0] data,
    output logic              ready,
    output logic              err
);

    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_wait_states_check
        $error("mem_responder: WAIT_STATES must be in 0..15");
    end

    localparam logic [CNT_W-1:0] WS_CNT = CNT_W'(WAIT_STATES);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              capture;
    logic              oor_n;

    logic              rw_q;
    logic              oor_q;
    logic [ADDR_W-1:0] idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] data_q;
    logic              ready_q;
    logic              err_q;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_index;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] rd_value;

    assign capture = (state == IDLE) && req;
    assign oor_n   = capture ? out_of_range(address, ADDR_W) : oor_q;

    // In IDLE the RAM looks at the live address so a zero-wait read has its word by DONE.
    assign ram_index = (state == IDLE) ? address[ADDR_W-1:0] : idx_q;
    assign ram_we    = (state == DONE) && (rw_q == BUS_WRITE) && !oor_q;
    assign rd_value  = oor_q ? '0 : ram_rdata;

    // Next-state and wait-counter logic.
    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    cnt_n   = WS_CNT;
                    state_n = (WAIT_STATES == 0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                cnt_n = cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State, counter, latched request and registered handshake outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            rw_q    <= BUS_READ;
            oor_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            ready_q <= (state_n == DONE);
            err_q   <= (state_n == DONE) && oor_n;
            if (capture) begin
                rw_q    <= rw;
                oor_q   <= oor_n;
                idx_q   <= address[ADDR_W-1:0];
                wdata_q <= datai;
            end
        end
    end

    // Hold the last completed read so data stays stable between reads.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
        end else if (state == DONE && rw_q == BUS_READ) begin
            data_q <= rd_value;
        end
    end

    assign data  = (state == DONE && rw_q == BUS_READ) ? rd_value : data_q;
    assign ready = ready_q;
    assign err   = err_q;

    mem_array #(.ADDR_W(ADDR_W)) u_mem (
        .clock (clock),
        .we    (ram_we),
        .index (ram_index),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: one responder with two wait states (index 0) and one with
// none (index 1), driven on falling edges and sampled on falling edges.
module tb_mem_responder;
    import bus_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst_a, req_a, rw_a, ready_a, err_a;
    logic [31:0] addr_a, datai_a, data_a;
    logic        rst_z, req_z, rw_z, ready_z, err_z;
    logic [31:0] addr_z, datai_z, data_z;

    mem_responder #(.ADDR_W(10), .WAIT_STATES(2)) dut_a (
        .clock(clock), .reset(rst_a), .req(req_a), .rw(rw_a), .address(addr_a),
        .datai(datai_a), .data(data_a), .ready(ready_a), .err(err_a)
    );

    mem_responder #(.ADDR_W(10), .WAIT_STATES(0)) dut_z (
        .clock(clock), .reset(rst_z), .req(req_z), .rw(rw_z), .address(addr_z),
        .datai(datai_z), .data(data_z), .ready(ready_z), .err(err_z)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: per-instance RAM image, which words are known, last read value.
    logic [31:0] m     [2][1024];
    bit          known [2][1024];
    logic [31:0] last_rd    [2];
    bit          last_known [2];

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic int ws_of(input bit z);
        return z ? 0 : 2;
    endfunction

    function automatic logic rdy(input bit z);
        return z ? ready_z : ready_a;
    endfunction

    function automatic logic er(input bit z);
        return z ? err_z : err_a;
    endfunction

    function automatic logic [31:0] dat(input bit z);
        return z ? data_z : data_a;
    endfunction

    task automatic drive(input bit z, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        if (z) begin
            req_z = r; rw_z = w; addr_z = a; datai_z = d;
        end else begin
            req_a = r; rw_a = w; addr_a = a; datai_a = d;
        end
    endtask

    // One request; lat is the number of falling edges after the capture edge until ready.
    task automatic txn(input bit z, input logic w, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic [31:0] rd, output logic e);
        @(negedge clock);
        drive(z, 1'b1, w, a, d);
        @(posedge clock);
        #1 drive(z, 1'b0, 1'($urandom_range(1)), $urandom, $urandom);
        lat = -1;
        rd  = 'x;
        e   = 1'bx;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (rdy(z)) begin
                lat = k;
                rd  = dat(z);
                e   = er(z);
                break;
            end
        end
        if (lat < 0) begin
            n_checks++;
            $display("FAIL ready_timeout: no ready within 40 cycles, expected one");
        end else begin
            @(negedge clock);
            check("ready_pulse_width", 64'(rdy(z)), 64'(0));
        end
    endtask

    task automatic op(input bit z, input logic w, input logic [31:0] a, input logic [31:0] d);
        int          lat;
        logic [31:0] rd;
        logic        e;
        bit          oor;
        int          idx;
        logic [31:0] exp;
        oor = (a >> 10) != 0;
        idx = int'(a[9:0]);
        txn(z, w, a, d, lat, rd, e);
        check("latency", 64'(lat), 64'(ws_of(z) + 1));
        check("err", 64'(e), 64'(oor));
        if (w == BUS_READ) begin
            exp = oor ? 32'h0 : m[z][idx];
            if (oor || known[z][idx]) begin
                check("read_data", 64'(rd), 64'(exp));
                last_rd[z]    = exp;
                last_known[z] = 1'b1;
            end else begin
                last_known[z] = 1'b0;
            end
        end else begin
            if (last_known[z]) check("write_keeps_data", 64'(rd), 64'(last_rd[z]));
            if (!oor) begin
                m[z][idx]     = d;
                known[z][idx] = 1'b1;
            end
        end
    endtask

    // Hold req for n_req cycles with changing addresses; only free-cycle samples are served.
    task automatic burst(input bit z, input int n_req, input logic [31:0] base);
        int          ws;
        int          next_free;
        int          exp_pos [$];
        logic [31:0] exp_dat [$];
        int          got_pos [$];
        logic [31:0] got_dat [$];
        ws        = ws_of(z);
        next_free = 0;
        for (int j = 0; j < n_req; j++) begin
            if (j >= next_free) begin
                exp_pos.push_back(j + ws + 1);
                exp_dat.push_back(m[z][int'(base[9:0]) + j]);
                next_free = j + ws + 2;
            end
        end
        for (int j = 0; j < n_req + ws + 4; j++) begin
            @(negedge clock);
            if (rdy(z)) begin
                got_pos.push_back(j);
                got_dat.push_back(dat(z));
            end
            if (j < n_req) drive(z, 1'b1, BUS_READ, base + 32'(j), $urandom);
            else           drive(z, 1'b0, BUS_READ, 32'h0, 32'h0);
        end
        check("burst_ready_count", 64'(got_pos.size()), 64'(exp_pos.size()));
        for (int k = 0; k < exp_pos.size() && k < got_pos.size(); k++) begin
            check($sformatf("burst_pos%0d", k), 64'(got_pos[k]), 64'(exp_pos[k]));
            check($sformatf("burst_data%0d", k), 64'(got_dat[k]), 64'(exp_dat[k]));
        end
        if (exp_dat.size() > 0) begin
            last_rd[z]    = exp_dat[exp_dat.size() - 1];
            last_known[z] = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        e;

        vecs[0] = '{BUS_WRITE, 32'h0000_0000, 32'h0BAD_F00D, 1'b0, 32'h0000_0000};
        vecs[1] = '{BUS_WRITE, 32'h0000_0005, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
        vecs[2] = '{BUS_READ,  32'h0000_0005, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[3] = '{BUS_WRITE, 32'h0000_0400, 32'hFFFF_FFFF, 1'b1, 32'hDEAD_BEEF};
        vecs[4] = '{BUS_READ,  32'h0000_0000, 32'h0,         1'b0, 32'h0BAD_F00D};
        vecs[5] = '{BUS_READ,  32'h0000_0400, 32'h0,         1'b1, 32'h0000_0000};
        vecs[6] = '{BUS_READ,  32'h8000_0005, 32'h0,         1'b1, 32'h0000_0000};
        vecs[7] = '{BUS_WRITE, 32'h0000_03FF, 32'hCAFE_F00D, 1'b0, 32'h0000_0000};
        vecs[8] = '{BUS_READ,  32'h0000_03FF, 32'h0,         1'b0, 32'hCAFE_F00D};

        for (int z = 0; z < 2; z++) begin
            for (int i = 0; i < 1024; i++) known[z][i] = 1'b0;
            last_rd[z]    = 32'h0;
            last_known[z] = 1'b1;
        end

        // Reset held for 3 cycles, then 10 idle cycles.
        rst_a = 1'b0; rst_z = 1'b0;
        drive(0, 1'b0, BUS_READ, 32'h0, 32'h0);
        drive(1, 1'b0, BUS_READ, 32'h0, 32'h0);
        repeat (3) @(negedge clock);
        check("reset_outputs_a", {31'h0, ready_a, err_a, data_a}, 64'h0);
        check("reset_outputs_z", {31'h0, ready_z, err_z, data_z}, 64'h0);
        rst_a = 1'b1; rst_z = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check($sformatf("idle_a%0d", i), {31'h0, ready_a, err_a, data_a}, 64'h0);
            check($sformatf("idle_z%0d", i), {31'h0, ready_z, err_z, data_z}, 64'h0);
        end

        // Directed vectors on the two-wait-state instance.
        for (int i = 0; i < 9; i++) begin
            txn(0, vecs[i].rw, vecs[i].addr, vecs[i].wdata, lat, rd, e);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(3));
            check($sformatf("vec%0d_err", i), 64'(e), 64'(vecs[i].exp_err));
            check($sformatf("vec%0d_data", i), 64'(rd), 64'(vecs[i].exp_data));
            if (vecs[i].rw == BUS_WRITE && !vecs[i].exp_err) begin
                m[0][int'(vecs[i].addr[9:0])]     = vecs[i].wdata;
                known[0][int'(vecs[i].addr[9:0])] = 1'b1;
            end
            if (vecs[i].rw == BUS_READ) last_rd[0] = vecs[i].exp_data;
        end

        // Read data persists after the ready pulse.
        op(0, BUS_READ, 32'h5, 32'h0);
        repeat (5) @(negedge clock);
        check("data_hold_5_cycles", 64'(data_a), 64'(32'hDEAD_BEEF));
        check("err_low_outside_done", 64'(err_a), 64'(0));

        // Zero wait states: write then read the top word.
        op(1, BUS_WRITE, 32'h3FF, 32'h1234_5678);
        op(1, BUS_READ,  32'h3FF, 32'h0);
        for (int i = 0; i < 10; i++) op(1, BUS_WRITE, 32'h40 + 32'(i), $urandom);
        burst(1, 10, 32'h40);

        // Continuous req with changing address on the two-wait-state instance.
        for (int i = 0; i < 8; i++) op(0, BUS_WRITE, 32'h20 + 32'(i), $urandom);
        burst(0, 8, 32'h20);

        // Reset during WAIT aborts a write.
        op(0, BUS_WRITE, 32'h10, 32'h1111_2222);
        @(negedge clock);
        drive(0, 1'b1, BUS_WRITE, 32'h10, 32'hA5A5_A5A5);
        @(posedge clock);
        #1 drive(0, 1'b0, BUS_READ, 32'h0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (i == 0) rst_a = 1'b0;
            if (i == 3) rst_a = 1'b1;
            check($sformatf("abort_no_ready%0d", i), 64'(ready_a), 64'(0));
        end
        check("abort_data_cleared", 64'(data_a), 64'(0));
        last_rd[0] = 32'h0;
        op(0, BUS_READ, 32'h10, 32'h0);

        // Randomized traffic on both instances against the model.
        for (int i = 0; i < 80; i++) begin
            bit          z;
            logic [31:0] a;
            z = (i % 4) == 3;
            a = 32'($urandom_range(15));
            if ($urandom_range(7) == 0) a = $urandom | 32'h400;
            op(z, 1'($urandom_range(1)), a, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the 32-bit CPU bus. The CPU is the initiator and drives address, write data and rw; this block decodes each request, applies a fixed number of wait states, then commits the write or returns the read data.
- Sits between the CPU core and the on-chip word RAM.
- Adds a single-cycle req/ready handshake so that CPU bus cycles become explicit transactions.

Parameters:
- ADDR_W, 10, word-index width; the RAM holds 2**ADDR_W 32-bit words.
- WAIT_STATES, 2, extra cycles between request capture and ready (legal range 0..15).

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  request strobe from the CPU; sampled only in IDLE.
- rw  in  1  1 = write, 0 = read.
- address  in  32  word address from the CPU.
- datai  in  32  write data, driven from CPU datao.
- data  out  32  read data, driven to CPU data.
- ready  out  1  one-cycle completion pulse.
- err  out  1  out-of-range flag; valid while ready=1.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, ready=0, err=0, data=0, wait counter=0, latched request cleared.
  - RAM contents are not cleared.
- States and transitions:
  - IDLE: on req=1, latch address, rw and datai; load the counter with WAIT_STATES.
    - Go to WAIT if WAIT_STATES>0, else go to DONE.
  - WAIT: decrement the counter each cycle. Go to DONE in the cycle after the counter reaches 0.
  - DONE: ready=1 for exactly this one cycle; go to IDLE next cycle.
- Latency: ready is asserted exactly WAIT_STATES+1 cycles after the clock edge that samples req.
- Throughput: the earliest next request is sampled in the cycle after DONE, i.e. one request per WAIT_STATES+2 cycles.
- req while in WAIT or DONE is ignored; it is neither queued nor latched.
- The CPU need not hold address, rw or datai after the capture edge; the latched copies are used.
- Decode:
  - In range: address[31:ADDR_W]==0. Index = address[ADDR_W-1:0].
  - Out of range (any upper bit set): write is dropped, read returns 0, err=1 during DONE.
- Write:
  - The RAM word is updated on the clock edge that ends DONE.
  - data is unchanged by a write.
- Read:
  - data holds RAM[index] during DONE and keeps that value until the next read completes.
  - A read issued right after a write to the same index returns the new value.
- err: registered, equal to 0 outside DONE.
- Reset asserted mid-transaction:
  - The transaction is aborted and no write commits.
  - ready stays 0; the block returns to IDLE on reset release.
- Reset release: req may be sampled on the first rising edge with reset=1.
- Widths: the counter is 4 bits. WAIT_STATES>15 is illegal and is checked by an elaboration-time assertion.

Decomposition:
- Shared package (bus_pkg):
  - State encoding: IDLE=2'd0, WAIT=2'd1, DONE=2'd2.
  - Constants: BUS_WRITE=1'b1, BUS_READ=1'b0.
  - Data width constant 32, reused by the CPU side.
- One sub-module, mem_array:
  - Single-port synchronous RAM of 2**ADDR_W x 32.
  - Inputs: we, index, wdata. Output: rdata.
  - Read-during-write returns old data. The FSM never reads and writes in the same cycle.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release, req=0 for 10 cycles -> ready=0, err=0, data=0 throughout.
- Write/read, WAIT_STATES=2:
  - Write 0xDEADBEEF to address 0x0000_0005 -> ready pulses 3 cycles after the req edge.
  - Read 0x5 -> data=0xDEADBEEF with ready, and data still holds it 5 cycles later.
- Zero wait states (WAIT_STATES=0):
  - Read address 0x3FF after writing 0x12345678 -> ready 1 cycle after capture with data=0x12345678.
  - Back-to-back requests are accepted every 2 cycles.
- Out of range:
  - Write 0xFFFFFFFF to address 0x0000_0400 (ADDR_W=10) -> err=1 with ready.
  - Subsequent read of 0x0 returns its prior value, and read of 0x400 returns data=0, err=1.
- Ignored request: assert req continuously for 8 cycles with the address changing each cycle -> only the addresses sampled in IDLE cycles are serviced; the ready count equals the number of IDLE samples.
- Reset mid-write: issue a write of 0xA5A5A5A5 to 0x10, assert reset during WAIT -> ready never pulses; after release, a read of 0x10 returns the pre-test value.
